// File: rtl/aes_core_arbiter_pkg.sv
// Shared widths, FSM encoding and default timing for the AES core arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_core_arbiter_pkg;

  localparam int AES_W            = 128;
  localparam int DEF_CORE_LATENCY = 11;
  localparam int DEF_CNT_W        = 8;

  typedef logic [AES_W-1:0] aes_blk_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Request, response and core-side signal bundle of the AES core arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on requests and response; core side has no flow control.
interface aes_core_arbiter_if;
  import aes_core_arbiter_pkg::*;

  logic     req0_valid;
  logic     req0_ready;
  aes_blk_t req0_plaintext;
  aes_blk_t req0_key;
  logic     req1_valid;
  logic     req1_ready;
  aes_blk_t req1_plaintext;
  aes_blk_t req1_key;
  logic     rsp_valid;
  logic     rsp_ready;
  logic     rsp_id;
  aes_blk_t rsp_data;
  logic     core_start;
  logic     core_en;
  aes_blk_t core_plaintext;
  aes_blk_t core_key;
  aes_blk_t core_cyphertext;
  logic     busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_plaintext, req0_key,
    input  req1_valid, req1_plaintext, req1_key,
    input  rsp_ready, core_cyphertext,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
    output core_start, core_en, core_plaintext, core_key, busy
  );

  // Client and core side.
  modport master (
    output req0_valid, req0_plaintext, req0_key,
    output req1_valid, req1_plaintext, req1_key,
    output rsp_ready, core_cyphertext,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
    input  core_start, core_en, core_plaintext, core_key, busy
  );

endinterface

// File: rtl/aes_core_arbiter_rr_arb2.sv
// Two-way round-robin grant: under contention the requester not granted last time wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module aes_core_arbiter_rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  // Pick the winner; a lone requester always wins regardless of history.
  always_comb begin
    gnt_vld_o = valid0_i | valid1_i;
    gnt_id_o  = 1'b0;
    if (valid0_i && valid1_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (valid1_i) begin
      gnt_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one fixed-latency AES-128 core between two requesters with round-robin grant.
// Latency: accept edge T -> core_start in cycle T -> rsp_valid from edge T+CORE_LATENCY+1.
// Backpressure: one job in flight; both requesters see ready=0 until the response is taken.
module aes_core_arbiter
  import aes_core_arbiter_pkg::*;
#(
  parameter int CORE_LATENCY = DEF_CORE_LATENCY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  aes_core_arbiter_if.slave bus
);

  // The core has no done flag, so the result is trusted on the cycle the
  // counter reaches its last value after start.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  aes_blk_t         pt_q, pt_d;
  aes_blk_t         key_q, key_d;
  aes_blk_t         data_q, data_d;
  logic             id_q, id_d;

  logic gnt_vld;
  logic gnt_id;
  logic accept;
  logic start;
  logic en;
  logic rsp_vld;

  aes_core_arbiter_rr_arb2 u_arb (
    .valid0_i     (bus.req0_valid),
    .valid1_i     (bus.req1_valid),
    .last_grant_i (last_grant_q),
    .gnt_vld_o    (gnt_vld),
    .gnt_id_o     (gnt_id)
  );

  // Next-state and per-state outputs; ready is masked while reset is held so
  // no requester believes a job was taken that the registers never latched.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    pt_d         = pt_q;
    key_d        = key_q;
    data_d       = data_q;
    id_d         = id_q;
    accept       = 1'b0;
    start        = 1'b0;
    en           = 1'b0;
    rsp_vld      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld && reset_n) begin
          accept       = 1'b1;
          pt_d         = gnt_id ? bus.req1_plaintext : bus.req0_plaintext;
          key_d        = gnt_id ? bus.req1_key       : bus.req0_key;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start   = 1'b1;
        en      = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        en    = 1'b1;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          data_d  = bus.core_cyphertext;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_vld = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand, result and fairness registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      pt_q         <= '0;
      key_q        <= '0;
      data_q       <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      data_q       <= data_d;
      id_q         <= id_d;
    end
  end

  assign bus.req0_ready     = accept & ~gnt_id;
  assign bus.req1_ready     = accept &  gnt_id;
  assign bus.rsp_valid      = rsp_vld;
  assign bus.rsp_id         = id_q;
  assign bus.rsp_data       = data_q;
  assign bus.core_start     = start;
  assign bus.core_en        = en;
  assign bus.core_plaintext = pt_q;
  assign bus.core_key       = key_q;
  assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a fixed-latency reference core model.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low during a response.
module tb_aes_core_arbiter;

  localparam int LAT = 11;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   start_cnt = 0;

  aes_core_arbiter_if bus();

  aes_core_arbiter #(.CORE_LATENCY(LAT), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.core_start) start_cnt <= start_cnt + 1;

  // Core model: result is correct only in the cycle that is LAT cycles after
  // the start cycle and inverted otherwise, so an early or late capture shows.
  int           core_cnt = 0;
  logic [127:0] core_f   = '0;

  function automatic logic [127:0] ref_core(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ key;
  endfunction

  always @(posedge clk) begin
    if (bus.core_start) begin
      core_cnt <= 1;
      core_f   <= ref_core(bus.core_plaintext, bus.core_key);
    end else if (bus.core_en && core_cnt != 0) begin
      core_cnt <= core_cnt + 1;
    end else begin
      core_cnt <= 0;
    end
  end

  assign bus.core_cyphertext = (core_cnt == LAT) ? core_f : ~core_f;

  function automatic logic [127:0] mk(input int r, input int i, input int k);
    logic [31:0] w;
    w = 32'h9e3779b9 * (r * 16 + i * 2 + k + 1);
    return {w, ~w, w ^ 32'h5555aaaa, w + 32'h1};
  endfunction

  task automatic clear_inputs();
    bus.req0_valid     = 1'b0;
    bus.req0_plaintext = '0;
    bus.req0_key       = '0;
    bus.req1_valid     = 1'b0;
    bus.req1_plaintext = '0;
    bus.req1_key       = '0;
    bus.rsp_ready      = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one job, waits for its accept and its response (both bounded).
  // Returns at the negedge of the first cycle with rsp_valid high; lat counts
  // negedge samples after the accept edge.
  task automatic run_job(input bit id, input logic [127:0] pt, input logic [127:0] key,
                         output int lat, output int acc_cyc, output bit tmo);
    int w;
    tmo = 1'b0; lat = 0; acc_cyc = 0; w = 0;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_plaintext = pt; bus.req1_key = key;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_plaintext = pt; bus.req0_key = key;
    end
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && w < 100) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 100) begin
      tmo = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 300) begin
      @(negedge clk); lat++;
    end
    if (!bus.rsp_valid) tmo = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.core_start,
         bus.core_en, bus.busy} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b required 0000000", {bus.req0_ready,
        bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.core_start, bus.core_en, bus.busy}); end
    checks++;
    if ((bus.rsp_data | bus.core_plaintext | bus.core_key) !== 128'h0)
      begin errors++; $display("FAIL reset_data: got %h required 0",
        bus.rsp_data | bus.core_plaintext | bus.core_key); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b000)
      begin errors++; $display("FAIL reset_idle: got %b required 000",
        {bus.busy, bus.req0_ready, bus.req1_ready}); end
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      begin errors++; $display("FAIL reset_first_grant: ready0/1 got %b required 10",
        {bus.req0_ready, bus.req1_ready}); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_single_job();
    int lat, acc; bit tmo;
    apply_reset();
    run_job(1'b0, FIPS_PT, FIPS_KEY, lat, acc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL single_timeout: got timeout required response"); end
    checks++;
    if (bus.rsp_id !== 1'b0)
      begin errors++; $display("FAIL single_id: got %b required 0", bus.rsp_id); end
    checks++;
    if (bus.rsp_data !== FIPS_CT)
      begin errors++; $display("FAIL single_data: got %h required %h", bus.rsp_data, FIPS_CT); end
    // RESP is entered on edge T+LAT+1, first seen on the LAT+2-th negedge sample.
    checks++;
    if (lat != LAT + 2)
      begin errors++; $display("FAIL single_latency: got %0d required %0d", lat, LAT + 2); end
  endtask

  task automatic test_contention();
    int n0, n1, w, bad_both;
    logic exp_id, g;
    logic [127:0] jpt, jkey;
    apply_reset();
    n0 = 0; n1 = 0; bad_both = 0; exp_id = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_plaintext = mk(0, 0, 0); bus.req0_key = mk(0, 0, 1);
    bus.req1_valid = 1'b1; bus.req1_plaintext = mk(1, 0, 0); bus.req1_key = mk(1, 0, 1);
    for (int j = 0; j < 8; j++) begin
      #1; w = 0;
      while (!(bus.req0_ready || bus.req1_ready) && w < 100) begin @(negedge clk); #1; w++; end
      checks++;
      if (w >= 100) begin errors++; $display("FAIL contention_grant_timeout job %0d", j); break; end
      if (bus.req0_ready && bus.req1_ready) bad_both++;
      g = bus.req1_ready;
      if (g !== exp_id)
        begin errors++; $display("FAIL contention_grant job %0d: got %b required %b", j, g, exp_id); end
      if (g) begin jpt = mk(1, n1, 0); jkey = mk(1, n1, 1); n1++; end
      else   begin jpt = mk(0, n0, 0); jkey = mk(0, n0, 1); n0++; end
      @(posedge clk);
      @(negedge clk);
      if (g) begin
        if (n1 < 4) begin bus.req1_plaintext = mk(1, n1, 0); bus.req1_key = mk(1, n1, 1); end
        else bus.req1_valid = 1'b0;
      end else begin
        if (n0 < 4) begin bus.req0_plaintext = mk(0, n0, 0); bus.req0_key = mk(0, n0, 1); end
        else bus.req0_valid = 1'b0;
      end
      w = 0;
      while (!bus.rsp_valid && w < 100) begin @(negedge clk); w++; end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== g || bus.rsp_data !== (jpt ^ jkey))
        begin errors++; $display("FAIL contention_rsp job %0d: got v=%b id=%b %h required v=1 id=%b %h",
          j, bus.rsp_valid, bus.rsp_id, bus.rsp_data, g, jpt ^ jkey); end
      exp_id = ~exp_id;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++;
    if (bad_both != 0 || n0 != 4 || n1 != 4)
      begin errors++; $display("FAIL contention_totals: both_ready=%0d n0=%0d n1=%0d required 0 4 4",
        bad_both, n0, n1); end
  endtask

  task automatic test_backpressure();
    int lat, acc, bad; bit tmo;
    logic [127:0] exp_d;
    apply_reset();
    bus.rsp_ready = 1'b0;
    exp_d = mk(2, 0, 0) ^ mk(2, 0, 1);
    run_job(1'b1, mk(2, 0, 0), mk(2, 0, 1), lat, acc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL bp_timeout: got timeout required response"); end
    bus.req0_valid = 1'b1; bus.req0_plaintext = mk(3, 0, 0); bus.req0_key = mk(3, 0, 1);
    bus.req1_valid = 1'b1; bus.req1_plaintext = mk(3, 1, 0); bus.req1_key = mk(3, 1, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== exp_d ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.core_en !== 1'b0 ||
          bus.core_start !== 1'b0 || bus.busy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: unstable cycles got %0d required 0", bad); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00)
      begin errors++; $display("FAIL bp_release: valid/busy got %b required 00", {bus.rsp_valid, bus.busy}); end
  endtask

  task automatic test_operand_stability();
    int w, bad, s0;
    logic [127:0] a, k;
    apply_reset();
    a = mk(4, 0, 0); k = mk(4, 0, 1);
    s0 = start_cnt;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_plaintext = a; bus.req0_key = k;
    #1; w = 0;
    while (!bus.req0_ready && w < 100) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req0_plaintext = mk(4, 1, 0); bus.req0_key = mk(4, 1, 1);
    bad = 0; w = 0;
    while (!bus.rsp_valid && w < 100) begin
      if (bus.core_plaintext !== a || bus.core_key !== k) bad++;
      @(negedge clk); w++;
    end
    checks++;
    if (bad != 0 || !bus.rsp_valid)
      begin errors++; $display("FAIL operand_hold: bad=%0d rsp_valid=%b required 0 1", bad, bus.rsp_valid); end
    checks++;
    if (bus.rsp_data !== (a ^ k))
      begin errors++; $display("FAIL operand_data: got %h required %h", bus.rsp_data, a ^ k); end
    @(negedge clk);
    checks++;
    if (bus.core_plaintext !== a)
      begin errors++; $display("FAIL operand_idle: got %h required %h", bus.core_plaintext, a); end
    checks++;
    if (start_cnt - s0 != 1)
      begin errors++; $display("FAIL start_pulse: got %0d required 1", start_cnt - s0); end
  endtask

  task automatic test_reset_mid_run();
    int w, bad;
    apply_reset();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_plaintext = mk(5, 0, 0); bus.req0_key = mk(5, 0, 1);
    #1; w = 0;
    while (!bus.req0_ready && w < 100) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    // Sample 1 is the ISSUE cycle, sample 2 is count 0, so sample 7 is count 5.
    repeat (7) @(negedge clk);
    bus.req0_valid = 1'b0;
    checks++;
    if ({bus.busy, bus.core_en} !== 2'b11)
      begin errors++; $display("FAIL midrun_pre: busy/en got %b required 11", {bus.busy, bus.core_en}); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.core_start,
         bus.core_en, bus.busy} !== 7'b0 ||
        (bus.rsp_data | bus.core_plaintext | bus.core_key) !== 128'h0)
      begin errors++; $display("FAIL midrun_clear: ctrl %b data %h required 0", {bus.req0_ready,
        bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.core_start, bus.core_en, bus.busy},
        bus.rsp_data | bus.core_plaintext | bus.core_key); end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (30) begin @(negedge clk); if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrun_ghost: cycles with activity got %0d required 0", bad); end
    bus.req0_valid = 1'b1; bus.req0_plaintext = mk(6, 0, 0); bus.req0_key = mk(6, 0, 1);
    bus.req1_valid = 1'b1; bus.req1_plaintext = mk(6, 1, 0); bus.req1_key = mk(6, 1, 1);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      begin errors++; $display("FAIL midrun_grant: ready0/1 got %b required 10",
        {bus.req0_ready, bus.req1_ready}); end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    w = 0;
    while (!bus.rsp_valid && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== (mk(6, 0, 0) ^ mk(6, 0, 1)))
      begin errors++; $display("FAIL midrun_next: got v=%b id=%b %h required v=1 id=0 %h",
        bus.rsp_valid, bus.rsp_id, bus.rsp_data, mk(6, 0, 0) ^ mk(6, 0, 1)); end
    @(negedge clk);
  endtask

  task automatic test_lone_requester();
    int lat, acc[3];
    bit tmo;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      run_job(1'b1, mk(7, i, 0), mk(7, i, 1), lat, acc[i], tmo);
      checks++;
      if (tmo || bus.rsp_id !== 1'b1 || bus.rsp_data !== (mk(7, i, 0) ^ mk(7, i, 1)))
        begin errors++; $display("FAIL lone_rsp job %0d: tmo=%b id=%b %h required 0 1 %h",
          i, tmo, bus.rsp_id, bus.rsp_data, mk(7, i, 0) ^ mk(7, i, 1)); end
    end
    checks++;
    if (acc[1] - acc[0] != LAT + 3 || acc[2] - acc[1] != LAT + 3)
      begin errors++; $display("FAIL lone_interval: got %0d %0d required %0d",
        acc[1] - acc[0], acc[2] - acc[1], LAT + 3); end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_job();
    test_contention();
    test_backpressure();
    test_operand_stability();
    test_reset_mid_run();
    test_lone_requester();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
